// File: rtl/gate_response_checker.sv
// Sequences the four {in_a,in_b} vectors into an external two-input gate and checks each response.
// Optional macro CHECKER_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT_TABLE  = 4'b1110,
  parameter int unsigned N_PASSES      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       in_a,
  output logic       in_b,
  input  logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] vec_idx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 32'd0) ? 4'(SETTLE_CYCLES - 32'd1) : 4'd0;
  localparam logic [3:0] PASS_LAST   = 4'(N_PASSES - 32'd1);

  state_t     state_q, state_d;
  logic [1:0] vec_idx_q, vec_idx_d;
  logic [3:0] err_count_q, err_count_d;
  logic [3:0] pass_cnt_q, pass_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       in_a_q, in_a_d;
  logic       in_b_q, in_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       mismatch_s;

  // Next-state, counter updates and next output values (outputs are flopped from the next state).
  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    err_count_d  = err_count_q;
    pass_cnt_d   = pass_cnt_q;
    settle_cnt_d = settle_cnt_q;
    mismatch_s   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = DRIVE;
          vec_idx_d    = 2'd0;
          err_count_d  = 4'd0;
          pass_cnt_d   = 4'd0;
          settle_cnt_d = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      DRIVE: begin
        settle_cnt_d = 4'd0;
        if (SETTLE_CYCLES == 32'd0) begin
          state_d = SAMPLE;
        end else begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        mismatch_s = (gate_out != EXPECT_TABLE[vec_idx_q]);
        // Saturate rather than wrap so a long failing run never reads as clean.
        if (mismatch_s && (err_count_q != 4'd15)) begin
          err_count_d = err_count_q + 4'd1;
        end else begin
          err_count_d = err_count_q;
        end
`ifdef CHECKER_STOP_ON_FAIL_EN
        if (mismatch_s) begin
          state_d = DONE;
        end else if (vec_idx_q != 2'd3) begin
          vec_idx_d = vec_idx_q + 2'd1;
          state_d   = DRIVE;
        end else begin
          vec_idx_d  = 2'd0;
          pass_cnt_d = pass_cnt_q + 4'd1;
          state_d    = (pass_cnt_q == PASS_LAST) ? DONE : DRIVE;
        end
`else
        if (vec_idx_q != 2'd3) begin
          vec_idx_d = vec_idx_q + 2'd1;
          state_d   = DRIVE;
        end else begin
          vec_idx_d  = 2'd0;
          pass_cnt_d = pass_cnt_q + 4'd1;
          state_d    = (pass_cnt_q == PASS_LAST) ? DONE : DRIVE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_count_d == 4'd0);
    in_a_d = busy_d ? vec_idx_d[1] : 1'b0;
    in_b_d = busy_d ? vec_idx_d[0] : 1'b0;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vec_idx_q    <= 2'd0;
      err_count_q  <= 4'd0;
      pass_cnt_q   <= 4'd0;
      settle_cnt_q <= 4'd0;
      in_a_q       <= 1'b0;
      in_b_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      err_count_q  <= err_count_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      in_a_q       <= in_a_d;
      in_b_q       <= in_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign in_a      = in_a_q;
  assign in_b      = in_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: idle cycles between applying a vector and sampling, legal range 0-15.
REQ-002 SHALL have parameter EXPECT_TABLE, default 4'b1110: expected gate output, bit index {in_a,in_b}, so the default is the two-input OR truth table.
REQ-003 SHALL have parameter N_PASSES, default 1: full truth-table sweeps per run, legal range 1-15.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: level-sampled run request.
REQ-007 SHALL have port in_a, output, 1: stimulus to gate input 1.
REQ-008 SHALL have port in_b, output, 1: stimulus to gate input 2.
REQ-009 SHALL have port gate_out, input, 1: response from the device under test.
REQ-010 SHALL have port busy, output, 1: high while a run is in progress.
REQ-011 SHALL have port done, output, 1: high in DONE state.
REQ-012 SHALL have port pass, output, 1: valid when done=1; 1 when no mismatch occurred.
REQ-013 SHALL have port err_count, output, 4: mismatch count, saturating.
REQ-014 SHALL have port vec_idx, output, 2: index {in_a,in_b} of the current vector.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE/DONE with start=1 SHALL go to DRIVE and clear vec_idx, err_count, pass count and settle counter in the same edge.
REQ-017 DRIVE SHALL drive in_a=vec_idx[1], in_b=vec_idx[0] for 1 cycle, then go to SETTLE; if SETTLE_CYCLES=0 it SHALL go directly to SAMPLE.
REQ-018 SETTLE SHALL hold the inputs for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL compare gate_out with EXPECT_TABLE[vec_idx]; on mismatch err_count SHALL increment, saturating at 15.
REQ-020 From SAMPLE with vec_idx<3, vec_idx SHALL increment and the FSM go to DRIVE; with vec_idx=3, vec_idx SHALL wrap to 0 and the pass count increment.
REQ-021 After the sample of vec_idx=3 in pass N_PASSES, the FSM SHALL go to DONE.
REQ-022 Per-vector time SHALL be SETTLE_CYCLES+2 cycles; a run SHALL take 4*N_PASSES*(SETTLE_CYCLES+2) cycles from start accept to done=1.
REQ-023 busy SHALL be 1 in DRIVE, SETTLE and SAMPLE; otherwise 0.
REQ-024 done SHALL be 1 only in DONE, and DONE SHALL hold until start or reset.
REQ-025 pass SHALL equal (err_count==0) in DONE and SHALL be 0 elsewhere.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 in_a and in_b SHALL hold their last values during SAMPLE and SHALL be 0 in IDLE and DONE.
REQ-028 A mismatch in SAMPLE at the same edge that err_count reaches 15 SHALL leave err_count at 15 and SHALL NOT wrap.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 With reset=1 at a clk edge, the FSM SHALL enter IDLE and in_a, in_b, busy, done, pass, err_count and vec_idx SHALL all be 0.
REQ-031 Reset SHALL take priority over start and over any state, including mid-SETTLE and mid-SAMPLE.
REQ-032 No mismatch SHALL be counted in the reset cycle.

Configuration
REQ-033 With macro CHECKER_STOP_ON_FAIL_EN defined, the first mismatch in SAMPLE SHALL send the FSM directly to DONE with err_count=1 and vec_idx holding the failing index.
REQ-034 Without CHECKER_STOP_ON_FAIL_EN, every vector of every pass SHALL be checked regardless of mismatches.

Verification
REQ-035 SHALL cover: default parameters, ideal OR gate, 1-cycle start pulse -> done=1 exactly 16 cycles later, pass=1, err_count=0, sequence 00,01,10,11 observed on {in_a,in_b}.
REQ-036 SHALL cover: gate_out stuck at 0, macro off -> done after 16 cycles, err_count=3, pass=0.
REQ-037 SHALL cover: AND gate as device under test, EXPECT_TABLE=4'b1110, N_PASSES=3 -> err_count=6, pass=0, done after 48 cycles.
REQ-038 SHALL cover: reset=1 during the second SETTLE cycle of vector 2 -> next cycle all outputs 0 and IDLE; a fresh start then completes normally.
REQ-039 SHALL cover: start held high throughout a run -> no restart while busy; a new run begins the cycle after DONE is entered.
REQ-040 SHALL cover: CHECKER_STOP_ON_FAIL_EN defined, gate_out stuck at 0 -> done after 8 cycles, err_count=1, vec_idx=1, pass=0.
